dcpu16_mbus_arb: RTL

Two-master to one-slave memory arbiter that sits directly downstream of the DCPU16 memory-bus controller. It accepts the F-BUS (data read/write) and G-BUS (operand/instruction fetch) simplified-Wishbone requests and serialises them onto a single shared memory port. It returns per-bus acknowledges and read data with the stall semantics the controller expects: the controller stalls while `stb` is high and `ack` is low.

---
 rtl/dcpu16_mbus_arb_if.sv | 47 ++++
 rtl/dcpu16_mbus_arb.sv | 98 +++++++++
 2 files changed

// File: rtl/dcpu16_mbus_arb_if.sv
// Bus bundle for the DCPU16 F/G to memory arbiter: both upstream request
// buses plus the shared memory port.
interface dcpu16_mbus_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] f_adr;
  logic          f_stb;
  logic          f_wre;
  logic [DW-1:0] f_dto;
  logic [DW-1:0] f_dti;
  logic          f_ack;

  logic [AW-1:0] g_adr;
  logic          g_stb;
  logic          g_wre;
  logic [DW-1:0] g_dto;
  logic [DW-1:0] g_dti;
  logic          g_ack;

  logic [AW-1:0] m_adr;
  logic          m_stb;
  logic          m_wre;
  logic [DW-1:0] m_dto;
  logic [DW-1:0] m_dti;
  logic          m_ack;

  // Arbiter view
  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack,
    input  g_adr, g_stb, g_wre, g_dto,
    output g_dti, g_ack,
    output m_adr, m_stb, m_wre, m_dto,
    input  m_dti, m_ack
  );

  // Environment view: controller buses and memory
  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack,
    output g_adr, g_stb, g_wre, g_dto,
    input  g_dti, g_ack,
    input  m_adr, m_stb, m_wre, m_dto,
    output m_dti, m_ack
  );
endinterface

// File: rtl/dcpu16_mbus_arb.sv
// Two-master (F data, G fetch) to one memory port arbiter with fixed F priority.
// All outputs are registered; each transaction takes request, memory and ack phases.
module dcpu16_mbus_arb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dcpu16_mbus_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FREQ,
    GREQ,
    FDONE,
    GDONE
  } state_t;

  state_t        state;
  logic [AW-1:0] m_adr;
  logic          m_stb;
  logic          m_wre;
  logic [DW-1:0] m_dto;
  logic [DW-1:0] f_dti;
  logic [DW-1:0] g_dti;
  logic          f_ack;
  logic          g_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m_adr <= '0;
      m_stb <= 1'b0;
      m_wre <= 1'b0;
      m_dto <= '0;
      f_dti <= '0;
      g_dti <= '0;
      f_ack <= 1'b0;
      g_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.f_stb) begin
            m_adr <= bus.f_adr;
            m_wre <= bus.f_wre;
            m_dto <= bus.f_dto;
            m_stb <= 1'b1;
            state <= FREQ;
          end else if (bus.g_stb) begin
            m_adr <= bus.g_adr;
            m_wre <= bus.g_wre;
            m_dto <= bus.g_dto;
            m_stb <= 1'b1;
            state <= GREQ;
          end
        end
        // The memory cycle completes even if the requester drops its strobe.
        FREQ: begin
          if (bus.m_ack) begin
            m_stb <= 1'b0;
            if (!m_wre) f_dti <= bus.m_dti;
            f_ack <= 1'b1;
            state <= FDONE;
          end
        end
        GREQ: begin
          if (bus.m_ack) begin
            m_stb <= 1'b0;
            if (!m_wre) g_dti <= bus.m_dti;
            g_ack <= 1'b1;
            state <= GDONE;
          end
        end
        // Strobes still show the request just served, so arbitration waits a cycle.
        FDONE: begin
          f_ack <= 1'b0;
          state <= IDLE;
        end
        GDONE: begin
          g_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_adr = m_adr;
  assign bus.m_stb = m_stb;
  assign bus.m_wre = m_wre;
  assign bus.m_dto = m_dto;
  assign bus.f_dti = f_dti;
  assign bus.g_dti = g_dti;
  assign bus.f_ack = f_ack;
  assign bus.g_ack = g_ack;

endmodule
